// File: rtl/reg_xfer_ctrl.sv
// reg_xfer_ctrl: one-command-at-a-time sequencer driving D/Load of a load-enabled register bank.
// Define REG_XFER_SWAP_EN to compile in the SWAP operation; otherwise op=11 is rejected with err.
module reg_xfer_ctrl #(
   parameter int NUM_REGS = 4,
   parameter int WIDTH    = 3,
   parameter int IDX_W    = $clog2(NUM_REGS)
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      req,
   input  logic [1:0]                op,
   input  logic [IDX_W-1:0]          src,
   input  logic [IDX_W-1:0]          dst,
   input  logic [WIDTH-1:0]          imm,
   input  logic [NUM_REGS*WIDTH-1:0] Q_in,
   output logic                      ready,
   output logic                      busy,
   output logic [WIDTH-1:0]          D_out,
   output logic [NUM_REGS-1:0]       Load,
   output logic                      done,
   output logic                      err
);

   typedef enum logic [1:0] {
      OP_LDI  = 2'b00,
      OP_MOV  = 2'b01,
      OP_INC  = 2'b10,
      OP_SWAP = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
`ifdef REG_XFER_SWAP_EN
      S_SWAP_W1,
      S_SWAP_W2,
`endif
      S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   src_q, src_d;
   logic [IDX_W-1:0]   dst_q, dst_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic               err_q, err_d;
`ifdef REG_XFER_SWAP_EN
   logic [WIDTH-1:0]   tmp_q, tmp_d;
   logic [WIDTH-1:0]   q_dst;
`endif

   logic [WIDTH-1:0]   q_src;
   logic               src_ok;
   logic               dst_ok;

   // Index decode doubles as the range check, so out-of-range indices never address Q_in.
   always_comb begin
      q_src  = '0;
      src_ok = 1'b0;
      dst_ok = 1'b0;
`ifdef REG_XFER_SWAP_EN
      q_dst  = '0;
`endif
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
         if (src == IDX_W'(k)) begin
            src_ok = 1'b1;
            q_src  = Q_in[k*WIDTH +: WIDTH];
         end
         if (dst == IDX_W'(k)) begin
            dst_ok = 1'b1;
`ifdef REG_XFER_SWAP_EN
            q_dst  = Q_in[k*WIDTH +: WIDTH];
`endif
         end
      end
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      data_d  = data_q;
      err_d   = err_q;
`ifdef REG_XFER_SWAP_EN
      tmp_d   = tmp_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               src_d = src;
               dst_d = dst;
               err_d = 1'b0;
               if (!(src_ok && dst_ok)) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  unique case (op_e'(op))
                     OP_LDI: begin
                        data_d  = imm;
                        state_d = S_WRITE;
                     end
                     OP_MOV: begin
                        data_d  = q_src;
                        state_d = S_WRITE;
                     end
                     OP_INC: begin
                        data_d  = q_src + WIDTH'(1);
                        state_d = S_WRITE;
                     end
                     OP_SWAP: begin
`ifdef REG_XFER_SWAP_EN
                        data_d  = q_dst;
                        tmp_d   = q_src;
                        state_d = S_SWAP_W1;
`else
                        err_d   = 1'b1;
                        state_d = S_DONE;
`endif
                     end
                     default: state_d = S_IDLE;
                  endcase
               end
            end
         end
         S_WRITE: state_d = S_DONE;
`ifdef REG_XFER_SWAP_EN
         // data_q is the bus register, so the second half of the swap reloads it from tmp_q.
         S_SWAP_W1: begin
            data_d  = tmp_q;
            state_d = S_SWAP_W2;
         end
         S_SWAP_W2: state_d = S_DONE;
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
`ifdef REG_XFER_SWAP_EN
         tmp_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         data_q  <= data_d;
         err_q   <= err_d;
`ifdef REG_XFER_SWAP_EN
         tmp_q   <= tmp_d;
`endif
      end
   end

   always_comb begin
      Load = '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
         if (state_q == S_WRITE && dst_q == IDX_W'(k)) Load[k] = 1'b1;
`ifdef REG_XFER_SWAP_EN
         if (state_q == S_SWAP_W1 && src_q == IDX_W'(k)) Load[k] = 1'b1;
         if (state_q == S_SWAP_W2 && dst_q == IDX_W'(k)) Load[k] = 1'b1;
`endif
      end
   end

   assign ready = (state_q == S_IDLE);
   assign busy  = (state_q != S_IDLE);
   assign done  = (state_q == S_DONE);
   assign err   = (state_q == S_DONE) && err_q;
   assign D_out = data_q;

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Bench for reg_xfer_ctrl: directed table, randomized commands against a transfer-level model,
// reset-abort, back-to-back and illegal-index sequences.
module tb_reg_xfer_ctrl;
   localparam int NR = 4;
   localparam int W  = 3;
`ifdef REG_XFER_SWAP_EN
   localparam bit SWAP_EN = 1'b1;
`else
   localparam bit SWAP_EN = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   logic          req = 1'b0;
   logic [1:0]    op  = '0;
   logic [1:0]    src = '0;
   logic [1:0]    dst = '0;
   logic [2:0]    imm = '0;
   logic [NR*W-1:0] Q_in;
   logic          ready, busy, done, err;
   logic [2:0]    D_out;
   logic [NR-1:0] Load;

   // Downstream register bank: plain load-enabled registers, not cleared by RST.
   logic [2:0] bank [NR] = '{default: '0};
   always_comb for (int k = 0; k < NR; k++) Q_in[k*W +: W] = bank[k];
   always @(posedge CLK) for (int k = 0; k < NR; k++) if (Load[k]) bank[k] <= D_out;

   reg_xfer_ctrl #(.NUM_REGS(NR), .WIDTH(W)) dut (
      .CLK(CLK), .RST(RST), .req(req), .op(op), .src(src), .dst(dst), .imm(imm),
      .Q_in(Q_in), .ready(ready), .busy(busy), .D_out(D_out), .Load(Load),
      .done(done), .err(err));

   logic       req3 = 1'b0;
   logic [1:0] op3  = '0;
   logic [1:0] src3 = '0;
   logic [1:0] dst3 = '0;
   logic [2:0] imm3 = '0;
   logic [8:0] q3   = 9'o742;
   logic       ready3, busy3, done3, err3;
   logic [2:0] D_out3;
   logic [2:0] Load3;

   reg_xfer_ctrl #(.NUM_REGS(3), .WIDTH(3)) dut3 (
      .CLK(CLK), .RST(RST), .req(req3), .op(op3), .src(src3), .dst(dst3), .imm(imm3),
      .Q_in(q3), .ready(ready3), .busy(busy3), .D_out(D_out3), .Load(Load3),
      .done(done3), .err(err3));

   int n_checks = 0;
   int n_errors = 0;
   int mreg [NR];
   int last_dout;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: a command is a list of (target register, value) writes computed from the
   // register contents at accept time; done follows the last write.
   task automatic run_cmd(input int o, input int s, input int d, input int iv,
                          output int ld1, output int do1, output int dcyc, output int er);
      int  nw, dc, hold;
      bit  illegal;
      int  eload [2];
      int  edout [2];
      int  eidx  [2];
      illegal = (o == 3) && !SWAP_EN;
      nw = 0;
      eload = '{0, 0}; edout = '{0, 0}; eidx = '{0, 0};
      if (!illegal) begin
         case (o)
            0: begin nw = 1; eidx[0] = d; edout[0] = iv; end
            1: begin nw = 1; eidx[0] = d; edout[0] = mreg[s]; end
            2: begin nw = 1; eidx[0] = d; edout[0] = (mreg[s] + 1) % 8; end
            default: begin
               nw = 2;
               eidx[0] = s; edout[0] = mreg[d];
               eidx[1] = d; edout[1] = mreg[s];
            end
         endcase
      end
      for (int w = 0; w < nw; w++) eload[w] = 1 << eidx[w];
      dc   = nw + 1;
      hold = last_dout;
      ld1 = -1; do1 = -1; dcyc = 0; er = 0;

      @(negedge CLK);
      chk("ready_pre", ready, 1);
      req = 1'b1; op = 2'(o); src = 2'(s); dst = 2'(d); imm = 3'(iv);
      @(posedge CLK);
      @(negedge CLK);
      req = 1'b0;
      for (int c = 1; c <= dc; c++) begin
         if (c > 1) @(negedge CLK);
         if (c == 1) begin ld1 = int'(Load); do1 = int'(D_out); end
         if (done && dcyc == 0) begin dcyc = c; er = int'(err); end
         if (c <= nw) begin
            chk("load", Load, eload[c-1]);
            chk("dout", D_out, edout[c-1]);
            hold = edout[c-1];
         end else begin
            chk("load_idle", Load, 0);
            chk("dout_hold", D_out, hold);
         end
         chk("done", done, int'(c == dc));
         chk("err", err, int'((c == dc) && illegal));
         chk("busy", busy, 1);
      end
      @(negedge CLK);
      chk("ready_post", ready, 1);
      chk("done_post", done, 0);
      for (int w = 0; w < nw; w++) mreg[eidx[w]] = edout[w];
      last_dout = hold;
      for (int k = 0; k < NR; k++) chk("bank", bank[k], mreg[k]);
   endtask

   task automatic run3(input int o, input int s, input int d, input int iv, input bit bad);
      @(negedge CLK);
      chk("r3_ready_pre", ready3, 1);
      req3 = 1'b1; op3 = 2'(o); src3 = 2'(s); dst3 = 2'(d); imm3 = 3'(iv);
      @(posedge CLK);
      @(negedge CLK);
      req3 = 1'b0;
      chk("r3_busy", busy3, 1);
      if (bad) begin
         chk("r3_load_bad", Load3, 0);
         chk("r3_done_bad", done3, 1);
         chk("r3_err_bad", err3, 1);
      end else begin
         chk("r3_load", Load3, 1 << d);
         chk("r3_dout", D_out3, iv);
         chk("r3_done_early", done3, 0);
         @(negedge CLK);
         chk("r3_load_off", Load3, 0);
         chk("r3_done", done3, 1);
         chk("r3_err", err3, 0);
      end
      @(negedge CLK);
      chk("r3_ready_post", ready3, 1);
      chk("r3_done_post", done3, 0);
   endtask

   typedef struct {
      int op; int s; int d; int imm;
      int load1; int dout1; int done_cyc; int err; int reg_after;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int ld1, do1, dcyc, er;
      int ro, rd, exp_ld, exp_d;
      int nacc, ndone, seen;
      int acc [3];

      tbl[0] = '{0, 0, 2, 5, 4, 5, 2, 0, 5};
      tbl[1] = '{1, 2, 0, 0, 1, 5, 2, 0, 5};
      tbl[2] = '{0, 0, 1, 7, 2, 7, 2, 0, 7};
      tbl[3] = '{2, 1, 1, 0, 2, 0, 2, 0, 0};
      tbl[4] = '{0, 0, 0, 6, 1, 6, 2, 0, 6};
      tbl[5] = '{0, 0, 3, 1, 8, 1, 2, 0, 1};
`ifdef REG_XFER_SWAP_EN
      tbl[6] = '{3, 0, 3, 0, 1, 1, 3, 0, 6};
      tbl[7] = '{2, 3, 2, 0, 4, 7, 2, 0, 7};
`else
      tbl[6] = '{3, 0, 3, 0, 0, 1, 1, 1, 1};
      tbl[7] = '{2, 3, 2, 0, 4, 2, 2, 0, 2};
`endif
      for (int k = 0; k < NR; k++) mreg[k] = 0;
      last_dout = 0;

      RST = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_ready", ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_load", Load, 0);
      chk("rst_dout", D_out, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_ready3", ready3, 1);
      RST = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_cmd(tbl[i].op, tbl[i].s, tbl[i].d, tbl[i].imm, ld1, do1, dcyc, er);
         chk("tbl_load1", ld1, tbl[i].load1);
         chk("tbl_dout1", do1, tbl[i].dout1);
         chk("tbl_done_cyc", dcyc, tbl[i].done_cyc);
         chk("tbl_err", er, tbl[i].err);
         chk("tbl_reg", bank[tbl[i].d], tbl[i].reg_after);
      end

      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge CLK);
         run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), ld1, do1, dcyc, er);
      end

      // Reset in the first write cycle: that write still lands, nothing after it does.
      ro = SWAP_EN ? 3 : 0;
      rd = SWAP_EN ? 3 : 2;
      exp_ld = SWAP_EN ? 1 : (1 << rd);
      exp_d  = SWAP_EN ? mreg[rd] : 3;
      @(negedge CLK);
      chk("rstmid_ready_pre", ready, 1);
      req = 1'b1; op = 2'(ro); src = 2'd0; dst = 2'(rd); imm = 3'd3;
      @(posedge CLK);
      @(negedge CLK);
      req = 1'b0;
      chk("rstmid_load_w1", Load, exp_ld);
      chk("rstmid_dout_w1", D_out, exp_d);
      RST = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      chk("rstmid_load", Load, 0);
      chk("rstmid_ready", ready, 1);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_done", done, 0);
      chk("rstmid_dout", D_out, 0);
      RST = 1'b0;
      seen = 0;
      repeat (4) begin
         @(negedge CLK);
         if (done || Load != 0) seen = 1;
      end
      chk("rstmid_no_done", seen, 0);
      mreg[SWAP_EN ? 0 : rd] = exp_d;
      last_dout = 0;
      for (int k = 0; k < NR; k++) chk("rstmid_bank", bank[k], mreg[k]);
      run_cmd(0, 0, 2, 4, ld1, do1, dcyc, er);

      // req held high: accepts must be three cycles apart, requests while busy dropped.
      nacc = 0; ndone = 0;
      @(negedge CLK);
      req = 1'b1; op = 2'd0; src = 2'd0; dst = 2'd1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (cyc > 0) @(negedge CLK);
         if (done) ndone++;
         if (nacc < 3 && ready) begin
            acc[nacc] = cyc;
            imm = 3'(nacc + 1);
            nacc++;
         end else if (nacc == 3) begin
            req = 1'b0;
         end
      end
      chk("b2b_accepts", nacc, 3);
      chk("b2b_gap1", acc[1] - acc[0], 3);
      chk("b2b_gap2", acc[2] - acc[1], 3);
      chk("b2b_dones", ndone, 3);
      chk("b2b_reg", bank[1], 3);
      mreg[1] = 3;
      last_dout = 3;
      run_cmd(1, 1, 3, 0, ld1, do1, dcyc, er);

      run3(0, 0, 3, 5, 1'b1);
      run3(1, 3, 0, 0, 1'b1);
      run3(0, 0, 2, 4, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
